mul_issue_ctrl: RTL and testbench
=================================

# mul_issue_ctrl

Issue/retire controller sitting directly in front of the sequential 16x16 multiplier. It accepts M-extension multiply requests (MUL, MULH, MULHSU, MULHU) from the execute stage. It drives the multiplier's enable, mode and operand inputs, waits on its hold handshake, and returns the 32-bit result with its destination register. A one-entry result cache lets an identical repeated request retire without invoking the multiplier.

## Interface
- CACHE_EN, 1, enables the one-entry result cache (0: every request goes to the multiplier).
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- stall  in  1  pipeline stall; freezes this block and is also wired to the multiplier.
- flush_i  in  1  pipeline flush; aborts any in-flight request.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request ready.
- funct3_i  in  3  [1:0]: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU; bit 2 ignored.
- rs1_i, rs2_i  in  32  operands.
- rd_i  in  5  destination register.
- rsp_valid_o  out  1  result valid.
- rsp_rd_o  out  5  destination of the result.
- rsp_data_o  out  32  result.
- busy_o  out  1  state != IDLE.
- mul_enable_o  out  1  multiplier enable_i.
- mul_first_o, mul_second_o  out  32  multiplier operands; registered, stable while busy.
- mul_signed_mode_o  out  2  MULH 2'b11, MULHSU 2'b01, MULHU and MUL 2'b00.
- mul_low_o  out  1  1 for MUL.
- mul_single_cycle_o  out  1  MUL with rs1[31:16]==0 and rs2[31:16]==0.
- mul_hold_i  in  1  multiplier hold_o.
- mul_result_i  in  32  multiplier result_o.

## Operation
- States: IDLE, LAUNCH, WAIT, RESP. They are one-hot encoded, and exactly one state is active at all times.
- req_ready_o = (state==IDLE) && !stall && !flush_i. Acceptance is req_valid_i && req_ready_o.
- On acceptance, register funct3, rs1, rs2 and rd, and derive the mode, low and single-cycle outputs from them.
- Cache hit: CACHE_EN && cache_valid && funct3[1:0], rs1 and rs2 all equal the cached key. On a hit, go IDLE→RESP with the cached data.
- Cache miss: go IDLE→LAUNCH.
- LAUNCH: mul_enable_o=1. The multiplier leaves its IDLE state this cycle. mul_hold_i is ignored here, because it is 0 while the multiplier is idle. Next state is WAIT.
- WAIT: mul_enable_o=1. On the first cycle with !mul_hold_i && !stall:
  - capture mul_result_i into the response register;
  - write the cache key and data, and set cache_valid;
  - drop mul_enable_o on the next cycle;
  - go to RESP.
- RESP: rsp_valid_o=1 with rsp_rd_o and rsp_data_o. On the first cycle without stall, go to IDLE.
- stall freezes the state, all registers and all outputs. A request already showing rsp_valid_o stays valid until a cycle without stall.
- flush_i has priority over stall. Any state goes to IDLE on the next cycle: mul_enable_o=0, no response, cache_valid=0.
- A simultaneous flush_i and req_valid_i does not accept the request.
- Reset: state=IDLE and all outputs 0, including req_ready_o, which rises on the first clock after release. cache_valid=0 and all registers are cleared.
- Reset mid-operation drops the request silently.

## Timing
Acceptance happens at cycle T, with no stall. rsp_valid_o is then first high at:
- cache hit: T+1;
- MUL single-cycle path: T+3 (LAUNCH T+1, capture T+2);
- MUL multi-cycle path: T+5 (multiplier ALBL/ALBH/AHBL, capture T+4);
- MULH, MULHSU, MULHU: T+6 (capture T+5).

Other timing rules:
- Each stall cycle adds exactly one cycle of latency.
- The earliest next acceptance is the cycle after RESP retires, so back-to-back throughput is 1 request per (latency+1) cycles.
- mul_first_o, mul_second_o, mul_signed_mode_o, mul_low_o and mul_single_cycle_o are constant from LAUNCH until WAIT exits.

## Test plan
- MUL rs1=3, rs2=5, rd=7: single-cycle asserted; rsp_valid_o at T+3 with rd=7, data=0x0000000F; exactly one rsp pulse.
- MUL 0x00010000×0x00010000: single-cycle deasserted, mul_low_o=1; data=0x00000000 at T+5.
- 0xFFFFFFFF×0xFFFFFFFF, each at T+6:
  - MULH → 0x00000000, mode 11;
  - MULHU → 0xFFFFFFFE, mode 00;
  - MULHSU → 0xFFFFFFFF, mode 01.
- Cache: MULHU 0xFFFFFFFF×0xFFFFFFFF twice → second response at T+1, mul_enable_o never rises. Repeat with rd changed → new rd returned.
- Flush during WAIT: no rsp_valid_o, mul_enable_o=0 next cycle, busy_o=0 next cycle. An immediately repeated request misses the cache (full latency).
- Stall held 3 cycles in WAIT and 2 cycles in RESP: MUL 3×5 result 0x0000000F, rsp_valid_o high for 3 cycles, total latency T+8. reset_n asserted mid-WAIT → all outputs 0 asynchronously, IDLE after release.

Source files
------------

// File: rtl/mul_issue_ctrl.sv
// Issue/retire controller in front of the sequential 16x16 multiplier.
// Launches M-extension multiplies, waits on the multiplier hold, and caches the last result.
module mul_issue_ctrl #(
    parameter bit CACHE_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        flush_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    input  logic [4:0]  rd_i,
    output logic        rsp_valid_o,
    output logic [4:0]  rsp_rd_o,
    output logic [31:0] rsp_data_o,
    output logic        busy_o,
    output logic        mul_enable_o,
    output logic [31:0] mul_first_o,
    output logic [31:0] mul_second_o,
    output logic [1:0]  mul_signed_mode_o,
    output logic        mul_low_o,
    output logic        mul_single_cycle_o,
    input  logic        mul_hold_i,
    input  logic [31:0] mul_result_i
);

    localparam logic [3:0] ST_IDLE   = 4'b0001;
    localparam logic [3:0] ST_LAUNCH = 4'b0010;
    localparam logic [3:0] ST_WAIT   = 4'b0100;
    localparam logic [3:0] ST_RESP   = 4'b1000;

    // bit 0: first operand signed, bit 1: second operand signed
    function automatic logic [1:0] mode_of(input logic [1:0] f);
        logic [1:0] m;
        case (f)
            2'b01:   m = 2'b11;
            2'b10:   m = 2'b01;
            default: m = 2'b00;
        endcase
        return m;
    endfunction

    logic [3:0]  state_q, state_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        mul_enable_q, mul_enable_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [4:0]  rsp_rd_q, rsp_rd_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic [31:0] mul_first_q, mul_first_d;
    logic [31:0] mul_second_q, mul_second_d;
    logic [1:0]  mode_q, mode_d;
    logic        low_q, low_d;
    logic        single_q, single_d;
    logic [1:0]  funct_q, funct_d;
    logic        cache_valid_q, cache_valid_d;
    logic [65:0] cache_key_q, cache_key_d;
    logic [31:0] cache_data_q, cache_data_d;

    logic        accept_s;
    logic        hit_s;
    logic        unused_funct3_s;

    assign unused_funct3_s = funct3_i[2];

    assign req_ready_o        = ready_q && !stall && !flush_i;
    assign busy_o             = busy_q;
    assign mul_enable_o       = mul_enable_q;
    assign rsp_valid_o        = rsp_valid_q;
    assign rsp_rd_o           = rsp_rd_q;
    assign rsp_data_o         = rsp_data_q;
    assign mul_first_o        = mul_first_q;
    assign mul_second_o       = mul_second_q;
    assign mul_signed_mode_o  = mode_q;
    assign mul_low_o          = low_q;
    assign mul_single_cycle_o = single_q;

    // Acceptance and cache lookup against the incoming request
    always_comb begin
        accept_s = req_valid_i && req_ready_o;
        hit_s    = CACHE_EN && cache_valid_q &&
                   (cache_key_q == {funct3_i[1:0], rs1_i, rs2_i});
    end

    // Next-state and datapath update; flush beats stall, stall freezes everything
    always_comb begin
        state_d       = state_q;
        rsp_rd_d      = rsp_rd_q;
        rsp_data_d    = rsp_data_q;
        mul_first_d   = mul_first_q;
        mul_second_d  = mul_second_q;
        mode_d        = mode_q;
        low_d         = low_q;
        single_d      = single_q;
        funct_d       = funct_q;
        cache_valid_d = cache_valid_q;
        cache_key_d   = cache_key_q;
        cache_data_d  = cache_data_q;

        if (flush_i) begin
            state_d       = ST_IDLE;
            cache_valid_d = 1'b0;
        end else if (!stall) begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        funct_d      = funct3_i[1:0];
                        mul_first_d  = rs1_i;
                        mul_second_d = rs2_i;
                        rsp_rd_d     = rd_i;
                        mode_d       = mode_of(funct3_i[1:0]);
                        low_d        = (funct3_i[1:0] == 2'b00);
                        single_d     = (funct3_i[1:0] == 2'b00) &&
                                       (rs1_i[31:16] == 16'h0000) &&
                                       (rs2_i[31:16] == 16'h0000);
                        if (hit_s) begin
                            rsp_data_d = cache_data_q;
                            state_d    = ST_RESP;
                        end else begin
                            state_d    = ST_LAUNCH;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                // multiplier is still idle here, so its hold is meaningless
                ST_LAUNCH: state_d = ST_WAIT;
                ST_WAIT: begin
                    if (!mul_hold_i) begin
                        rsp_data_d    = mul_result_i;
                        cache_key_d   = {funct_q, mul_first_q, mul_second_q};
                        cache_data_d  = mul_result_i;
                        cache_valid_d = CACHE_EN;
                        state_d       = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                ST_RESP: state_d = ST_IDLE;
                default: begin
                    state_d       = ST_IDLE;
                    cache_valid_d = 1'b0;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        // all status outputs are registered decodes of the next state
        ready_d      = (state_d == ST_IDLE);
        busy_d       = (state_d != ST_IDLE);
        mul_enable_d = (state_d == ST_LAUNCH) || (state_d == ST_WAIT);
        rsp_valid_d  = (state_d == ST_RESP);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            ready_q       <= 1'b0;
            busy_q        <= 1'b0;
            mul_enable_q  <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rd_q      <= 5'd0;
            rsp_data_q    <= 32'h0000_0000;
            mul_first_q   <= 32'h0000_0000;
            mul_second_q  <= 32'h0000_0000;
            mode_q        <= 2'b00;
            low_q         <= 1'b0;
            single_q      <= 1'b0;
            funct_q       <= 2'b00;
            cache_valid_q <= 1'b0;
            cache_key_q   <= 66'd0;
            cache_data_q  <= 32'h0000_0000;
        end else begin
            state_q       <= state_d;
            ready_q       <= ready_d;
            busy_q        <= busy_d;
            mul_enable_q  <= mul_enable_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rd_q      <= rsp_rd_d;
            rsp_data_q    <= rsp_data_d;
            mul_first_q   <= mul_first_d;
            mul_second_q  <= mul_second_d;
            mode_q        <= mode_d;
            low_q         <= low_d;
            single_q      <= single_d;
            funct_q       <= funct_d;
            cache_valid_q <= cache_valid_d;
            cache_key_q   <= cache_key_d;
            cache_data_q  <= cache_data_d;
        end
    end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Scoreboard bench for mul_issue_ctrl with a behavioural sequential multiplier model.
module tb_mul_issue_ctrl;

    logic        clk;
    logic        reset_n;
    logic        stall;
    logic        flush_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [2:0]  funct3_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic [4:0]  rd_i;
    logic        rsp_valid_o;
    logic [4:0]  rsp_rd_o;
    logic [31:0] rsp_data_o;
    logic        busy_o;
    logic        mul_enable_o;
    logic [31:0] mul_first_o;
    logic [31:0] mul_second_o;
    logic [1:0]  mul_signed_mode_o;
    logic        mul_low_o;
    logic        mul_single_cycle_o;
    logic        mul_hold_i;
    logic [31:0] mul_result_i;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        int          lat;
        int          pulses;
        bit          en;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc   = 0;

    int   acc_cyc, first_cyc, pulses;
    bit   en_seen;

    bit          mactive;
    int          mrem;
    logic [63:0] a64, b64, prod;

    mul_issue_ctrl #(.CACHE_EN(1'b1)) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .stall              (stall),
        .flush_i            (flush_i),
        .req_valid_i        (req_valid_i),
        .req_ready_o        (req_ready_o),
        .funct3_i           (funct3_i),
        .rs1_i              (rs1_i),
        .rs2_i              (rs2_i),
        .rd_i               (rd_i),
        .rsp_valid_o        (rsp_valid_o),
        .rsp_rd_o           (rsp_rd_o),
        .rsp_data_o         (rsp_data_o),
        .busy_o             (busy_o),
        .mul_enable_o       (mul_enable_o),
        .mul_first_o        (mul_first_o),
        .mul_second_o       (mul_second_o),
        .mul_signed_mode_o  (mul_signed_mode_o),
        .mul_low_o          (mul_low_o),
        .mul_single_cycle_o (mul_single_cycle_o),
        .mul_hold_i         (mul_hold_i),
        .mul_result_i       (mul_result_i)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Multiplier model: hold for 0/2/3 WAIT cycles after the launch cycle, frozen by stall
    initial begin
        mul_hold_i = 1'b0;
        mul_result_i = 32'h0;
        mactive = 1'b0;
        mrem = 0;
        forever begin
            @(negedge clk);
            a64 = mul_signed_mode_o[0] ? {{32{mul_first_o[31]}}, mul_first_o} : {32'h0, mul_first_o};
            b64 = mul_signed_mode_o[1] ? {{32{mul_second_o[31]}}, mul_second_o} : {32'h0, mul_second_o};
            prod = a64 * b64;
            mul_result_i = mul_low_o ? prod[31:0] : prod[63:32];
            if (!reset_n || !mul_enable_o) begin
                mactive = 1'b0;
                mul_hold_i = 1'b0;
            end else if (!mactive) begin
                mactive = 1'b1;
                mrem = (mul_low_o && mul_single_cycle_o) ? 0 : (mul_low_o ? 2 : 3);
                mul_hold_i = 1'b0;
            end else begin
                mul_hold_i = (mrem > 0);
                if (!stall && mrem > 0) mrem--;
            end
        end
    end

    // Response monitor: pops the scoreboard on each retiring response
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (req_valid_i && req_ready_o) begin
                    acc_cyc = cyc;
                    pulses = 0;
                    en_seen = 1'b0;
                end
                if (mul_enable_o) en_seen = 1'b1;
                if (rsp_valid_o) begin
                    if (pulses == 0) first_cyc = cyc;
                    pulses++;
                    if (!stall && !flush_i) begin
                        if (sb_q.size() == 0) begin
                            check_eq("unexpected_rsp", 64'd1, 64'd0);
                        end else begin
                            e = sb_q.pop_front();
                            check_eq("rsp_rd", 64'(rsp_rd_o), 64'(e.rd));
                            check_eq("rsp_data", 64'(rsp_data_o), 64'(e.data));
                            check_eq("latency", 64'(first_cyc - acc_cyc), 64'(e.lat));
                            check_eq("rsp_pulses", 64'(pulses), 64'(e.pulses));
                            check_eq("mul_en_seen", 64'(en_seen), 64'(e.en));
                        end
                    end
                end
            end
        end
    end

    // Drive one request; returns at posedge+1 of the second cycle after acceptance
    task automatic send(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input bit push, input logic [31:0] exp_data,
                        input int exp_lat, input int exp_pulses, input bit exp_en,
                        input logic [3:0] exp_ctl);
        exp_t e;
        bit ok;
        funct3_i = f3;
        rs1_i = a;
        rs2_i = b;
        rd_i = rd;
        req_valid_i = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check_eq("accept_timeout", 64'd1, 64'd0);
            req_valid_i = 1'b0;
            return;
        end
        if (push) begin
            e.rd = rd;
            e.data = exp_data;
            e.lat = exp_lat;
            e.pulses = exp_pulses;
            e.en = exp_en;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        @(negedge clk);
        check_eq("mode_low_single", 64'({mul_signed_mode_o, mul_low_o, mul_single_cycle_o}), 64'(exp_ctl));
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && !busy_o) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check_eq("done_timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b1;
        stall = 1'b0;
        flush_i = 1'b0;
        req_valid_i = 1'b0;
        funct3_i = 3'd0;
        rs1_i = 32'h0;
        rs2_i = 32'h0;
        rd_i = 5'd0;
        #2;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_ctl", 64'({req_ready_o, busy_o, rsp_valid_o, mul_enable_o, mul_low_o, mul_single_cycle_o}), 64'd0);
        check_eq("reset_data", 64'({rsp_data_o, mul_first_o}), 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("ready_before_clk", 64'(req_ready_o), 64'd0);
        @(negedge clk);
        check_eq("ready_after_clk", 64'(req_ready_o), 64'd1);
        @(posedge clk);
        #1;

        // MUL single-cycle, MUL multi-cycle, then the three high-half variants
        send(3'b000, 32'd3, 32'd5, 5'd7, 1'b1, 32'h0000_000F, 3, 1, 1'b1, 4'b0011);
        wait_done();
        send(3'b000, 32'h0001_0000, 32'h0001_0000, 5'd8, 1'b1, 32'h0, 5, 1, 1'b1, 4'b0010);
        wait_done();
        send(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 1'b1, 32'h0, 6, 1, 1'b1, 4'b1100);
        wait_done();
        send(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 1'b1, 32'hFFFF_FFFE, 6, 1, 1'b1, 4'b0000);
        wait_done();
        send(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 1'b1, 32'hFFFF_FFFF, 6, 1, 1'b1, 4'b0100);
        wait_done();

        // Cache: first MULHU misses (cache holds MULHSU), repeats hit with new rd
        send(3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 1'b1, 32'hFFFF_FFFE, 6, 1, 1'b1, 4'b0000);
        wait_done();
        send(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd13, 1'b1, 32'hFFFF_FFFE, 1, 1, 1'b0, 4'b0000);
        wait_done();
        send(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd14, 1'b1, 32'hFFFF_FFFE, 1, 1, 1'b0, 4'b0000);
        wait_done();

        // Flush during WAIT, then the previously cached request must miss
        send(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd15, 1'b0, 32'h0, 0, 0, 1'b1, 4'b1100);
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        @(negedge clk);
        check_eq("flush_idle", 64'({rsp_valid_o, mul_enable_o, busy_o}), 64'd0);
        @(posedge clk);
        #1;
        send(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd16, 1'b1, 32'hFFFF_FFFE, 6, 1, 1'b1, 4'b0000);
        wait_done();

        // Flush together with a valid request must not accept it
        funct3_i = 3'b000;
        rs1_i = 32'd2;
        rs2_i = 32'd2;
        req_valid_i = 1'b1;
        flush_i = 1'b1;
        @(negedge clk);
        check_eq("flush_blocks_ready", 64'(req_ready_o), 64'd0);
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        flush_i = 1'b0;
        @(negedge clk);
        check_eq("flush_no_accept", 64'(busy_o), 64'd0);
        @(posedge clk);
        #1;

        // Stall 3 cycles in WAIT and 2 in RESP
        send(3'b000, 32'd3, 32'd5, 5'd17, 1'b1, 32'h0000_000F, 6, 3, 1'b1, 4'b0011);
        stall = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        stall = 1'b0;
        @(posedge clk);
        #1;
        stall = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        stall = 1'b0;
        wait_done();

        // Asynchronous reset in WAIT drops the request and clears the cache
        send(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd18, 1'b0, 32'h0, 0, 0, 1'b1, 4'b1100);
        #1;
        reset_n = 1'b0;
        #1;
        check_eq("async_rst_ctl", 64'({req_ready_o, busy_o, rsp_valid_o, mul_enable_o, rsp_rd_o,
                                       mul_signed_mode_o, mul_low_o, mul_single_cycle_o}), 64'd0);
        check_eq("async_rst_data", 64'({rsp_data_o, mul_first_o}), 64'd0);
        check_eq("async_rst_op2", 64'(mul_second_o), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("post_rst_idle", 64'({busy_o, req_ready_o}), 64'b01);
        @(posedge clk);
        #1;
        send(3'b000, 32'd3, 32'd5, 5'd19, 1'b1, 32'h0000_000F, 3, 1, 1'b1, 4'b0011);
        wait_done();

        check_eq("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
